// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder bus target.
// Legal byte-enable set is only enforced when MEM_RESPONDER_FAULT_EN is defined.
package mem_responder_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HLO  = 4'b0011;
    localparam logic [3:0] BE_HHI  = 4'b1100;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_B1   = 4'b0010;
    localparam logic [3:0] BE_B2   = 4'b0100;
    localparam logic [3:0] BE_B3   = 4'b1000;

    function automatic logic be_legal(input logic [3:0] be);
        return be inside {BE_WORD, BE_HLO, BE_HHI,
                          BE_B0, BE_B1, BE_B2, BE_B3};
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side request/response bus of one memory region.
// The initiator drives the master modport, the responder the slave one.
interface mem_responder_if;

    logic        bus_select;
    logic [31:0] bus_addr;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  bus_byteenable;
    logic [31:0] bus_data_in;
    logic [31:0] bus_data_out;
    logic        bus_wait;
    logic        bus_fault;

    modport master (
        output bus_select, bus_addr, bus_read, bus_write,
        output bus_byteenable, bus_data_in,
        input  bus_data_out, bus_wait, bus_fault
    );

    modport slave (
        input  bus_select, bus_addr, bus_read, bus_write,
        input  bus_byteenable, bus_data_in,
        output bus_data_out, bus_wait, bus_fault
    );

endinterface

// File: rtl/sram_1rw.sv
// Single-port synchronous word RAM with byte-lane writes.
// Read data is registered and held until the next read.
module sram_1rw #(
    parameter int AW = 12
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [31:0] mem_q [0:DEPTH-1];
    logic [31:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Only the output register is reset; array contents are not.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Wait-state bus responder in front of a word RAM.
// Define MEM_RESPONDER_FAULT_EN to enable byte-enable/opcode fault checking.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input logic            clock,
    input logic            reset_n,
    mem_responder_if.slave cpu
);

    localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req;
    logic             accept;
    logic             wait_o;
    logic             bad;
    logic             we;
    logic             re;
    logic [31:0]      rdata;
    logic             unused_addr;

    assign req = cpu.bus_select & (cpu.bus_read | cpu.bus_write);
    assign unused_addr = ^{cpu.bus_addr[31:ADDR_WIDTH+2],
                           cpu.bus_addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        wait_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        accept  = 1'b1;
                        state_d = DONE;
                    end else begin
                        wait_o  = 1'b1;
                        cnt_d   = 4'd1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt_q == WS) begin
                    accept  = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_o  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (!req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MEM_RESPONDER_FAULT_EN
    logic zero_q;
    logic fault_q;

    assign bad = ~be_legal(cpu.bus_byteenable)
               | (cpu.bus_read & cpu.bus_write);
    assign re  = accept & cpu.bus_read;

    // zero_q tracks the read that last loaded the RAM output register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zero_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            if (re) zero_q <= bad;
            if (accept && bad) fault_q <= 1'b1;
        end
    end

    assign cpu.bus_data_out = zero_q ? 32'h0 : rdata;
    assign cpu.bus_fault    = fault_q;
`else
    assign bad = 1'b0;
    assign re  = accept & cpu.bus_read & ~cpu.bus_write;

    assign cpu.bus_data_out = rdata;
    assign cpu.bus_fault    = 1'b0;
`endif

    assign we = accept & cpu.bus_write & ~bad;
    assign cpu.bus_wait = wait_o;

    sram_1rw #(
        .AW(ADDR_WIDTH)
    ) u_ram (
        .clock   (clock),
        .reset_n (reset_n),
        .we_i    (we),
        .re_i    (re),
        .be_i    (cpu.bus_byteenable),
        .addr_i  (cpu.bus_addr[ADDR_WIDTH+1:2]),
        .wdata_i (cpu.bus_data_in),
        .rdata_o (rdata)
    );

endmodule

// File: doc/mem_responder.md
# mem_responder

Bus target that answers the CPU's read/write bus protocol: it stretches each request with a programmable number of wait states on bus_wait, commits byte-enabled writes into an internal synchronous word RAM, and returns read data. It sits behind the system address decoder, one instance per on-chip memory region, and terminates bus cycles started by the CPU control unit.

## Interface
- ADDR_WIDTH, 12: word-address bits; RAM depth 2**ADDR_WIDTH words of 32 bits
- WAIT_STATES, 1: cycles bus_wait is held high per request, 0..15
- clock  in  1  system clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- bus_select  in  1  region decode from address decoder; qualifies bus_read/bus_write
- bus_addr  in  32  byte address; word index = bus_addr[ADDR_WIDTH+1:2], other bits ignored
- bus_read  in  1  read request, held by initiator until after acceptance
- bus_write  in  1  write request, held by initiator until acceptance
- bus_byteenable  in  4  bit i enables data bits [8i+7:8i]
- bus_data_in  in  32  write data
- bus_data_out  out  32  read data
- bus_wait  out  1  high = initiator must hold request
- bus_fault  out  1  sticky error flag (only with MEM_RESPONDER_FAULT_EN)

## Operation
- req = bus_select & (bus_read | bus_write).
- States: IDLE, WAIT, DONE.
- IDLE: on req with WAIT_STATES=0 -> accept this cycle, go DONE; with WAIT_STATES>0 -> count<=1, go WAIT.
- WAIT: if req dropped -> IDLE (abandoned, no side effect). Else if count==WAIT_STATES -> accept, go DONE; else count++.
- DONE: stay while req high; req low -> IDLE. No further commits in DONE.
- bus_wait (combinational) = req & (state==IDLE ? WAIT_STATES!=0 : state==WAIT & count!=WAIT_STATES). Low in DONE.
- Accept cycle: the single cycle with req high and bus_wait low outside DONE.
- Write accept: RAM word updated on enabled lanes only; disabled lanes unchanged.
- Read accept: RAM read issued; bus_data_out updated on next edge and held until the next accepted read.
- Request signals and bus_addr/data must be stable from first req cycle through accept.
- Initiator must drop req for at least one cycle between transactions; a held req is one transaction.

## Timing
- Reset: state IDLE, count 0, bus_data_out 32'h0, bus_fault 0; bus_wait follows req combinationally (IDLE). RAM contents not reset.
- Request first seen cycle 0: bus_wait high cycles 0..WAIT_STATES-1, low cycle WAIT_STATES (accept).
- Read data valid at cycle WAIT_STATES+1 (matches initiator latching one cycle after wait drops while still asserting read).
- Write visible to a read accepted at cycle WAIT_STATES+1 or later.
- Reset mid-WAIT: transaction dropped, no write committed.
- bus_read and bus_write both high: treated as write (with fault feature: faulted, see below).

## Configuration
- MEM_RESPONDER_FAULT_EN defined: at accept, bus_byteenable not in {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000}, or bus_read & bus_write both high -> write suppressed, read returns 32'h0, bus_fault set (sticky until reset). Handshake timing unchanged.
- Undefined: no checking; any byteenable pattern written as given; bus_fault tied 0.

## Structure
- Package mem_responder_pkg: state enum (IDLE, WAIT, DONE), legal byteenable constants, wait-counter width (4).
- Sub-module sram_1rw: synchronous single-port RAM, 32-bit words, per-byte write enable, registered read output; mem_responder holds FSM, counter, fault logic.

## Test plan
- WAIT_STATES=1: write 32'hDEADBEEF to 0x0010, be 4'b1111 -> bus_wait high 1 cycle, low on cycle 1; read 0x0010 -> bus_data_out 32'hDEADBEEF at cycle 2.
- Byte lanes: after above, write 32'h000000AA be 4'b0001 to 0x0010 -> readback 32'hDEADBEAA.
- WAIT_STATES=0: read request -> bus_wait never high, data valid cycle 1; held bus_read 3 cycles -> exactly one RAM access.
- Abort: bus_write dropped in WAIT, then read same address -> old value returned.
- Reset asserted during WAIT of write 32'h12345678 -> no write, bus_data_out 0, state IDLE, next request takes full WAIT_STATES.
- With MEM_RESPONDER_FAULT_EN: write be 4'b0110 -> word unchanged, bus_fault=1 and stays 1 across later good transactions until reset.
